// File: rtl/rr_arb4_mux_pkg.sv
// Shared types and the round-robin search used by the rr_arb4_mux arbiter.
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [1:0] idx;
        logic       found;
    } pick_t;

    // First set bit of req searching last+1, last+2, last+3, last (mod 4).
    function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] last);
        pick_t      p;
        logic [1:0] cand;
        p = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                p.idx   = cand;
                p.found = 1'b1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arb4_mux_if.sv
// Requester-side bus of the rr_arb4_mux arbiter: requests, data and the granted view.
interface rr_arb4_mux_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic [3:0]       grant;
    logic [1:0]       S;
    logic             busy;
    logic [WIDTH-1:0] Y;

    modport master (
        output req, D0, D1, D2, D3,
        input  grant, S, busy, Y
    );

    modport slave (
        input  req, D0, D1, D2, D3,
        output grant, S, busy, Y
    );
endinterface

// File: rtl/rr_arb4_mux_mux4.sv
// Plain 4:1 data multiplexer; the arbiter gates its output with busy.
module mux4_bus #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb begin
        y_o = '0;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            2'd3:    y_o = d3_i;
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/rr_arb4_mux.sv
// Four-way round-robin arbiter driving a shared 4:1 data mux.
// Optional hold limit (preempt a long owner when others wait) under RR_ARB_HOLD_LIMIT_EN.
module rr_arb4_mux
    import arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst,
    rr_arb4_mux_if.slave  bus
);
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4_mux: MAX_HOLD must be within 1..255");
    end

    arb_state_e state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] s_q, s_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cand;
    logic       rearb;
    pick_t      pick;
    logic [WIDTH-1:0] mux_y;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam logic [8:0] HoldMax9 = 9'(MAX_HOLD);
    localparam logic [7:0] HoldMax8 = 8'(MAX_HOLD);
    logic [7:0] hold_q, hold_d;
    logic [8:0] hold_inc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            s_q     <= 2'd0;
            last_q  <= 2'd3;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            s_q     <= s_d;
            last_q  <= last_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        s_d     = s_q;
        last_d  = last_q;
        cand    = bus.req;
        rearb   = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
        hold_d   = hold_q;
        hold_inc = {1'b0, hold_q} + 9'd1;
`endif
        case (state_q)
            ST_IDLE: rearb = 1'b1;
            ST_OWN: begin
                // s_q always names the current owner while in OWN
                if (!bus.req[s_q]) begin
                    rearb = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
                end else if (hold_inc >= HoldMax9 && |(bus.req & ~grant_q)) begin
                    rearb = 1'b1;
                    cand  = bus.req & ~grant_q;
                end else begin
                    hold_d = (hold_inc >= HoldMax9) ? HoldMax8 : hold_inc[7:0];
`endif
                end
            end
            default: rearb = 1'b1;
        endcase

        pick = rr_pick(cand, last_q);
        if (rearb) begin
            if (pick.found) begin
                state_d = ST_OWN;
                grant_d = 4'b0001 << pick.idx;
                s_d     = pick.idx;
                last_d  = pick.idx;
`ifdef RR_ARB_HOLD_LIMIT_EN
                hold_d  = 8'd0;
`endif
            end else begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
            end
        end
    end

    mux4_bus #(.WIDTH(WIDTH)) u_mux (
        .sel_i (s_q),
        .d0_i  (bus.D0),
        .d1_i  (bus.D1),
        .d2_i  (bus.D2),
        .d3_i  (bus.D3),
        .y_o   (mux_y)
    );

    assign bus.grant = grant_q;
    assign bus.S     = s_q;
    assign bus.busy  = (state_q == ST_OWN);
    assign bus.Y     = (state_q == ST_OWN) ? mux_y : '0;
endmodule

// File: tb/tb_rr_arb4_mux.sv
// Bench for rr_arb4_mux: owner-based reference model compared every cycle, plus literal checks.
module tb_rr_arb4_mux;
    localparam int W  = 8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] d [4];

    int checks   = 0;
    int failures = 0;

    rr_arb4_mux_if #(.WIDTH(W)) bus ();

    assign bus.req = req;
    assign bus.D0  = d[0];
    assign bus.D1  = d[1];
    assign bus.D2  = d[2];
    assign bus.D3  = d[3];

    rr_arb4_mux #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the resource, whose turn is next, how long it has held.
    int m_owner = -1;
    int m_s     = 0;
    int m_last  = 3;
    int m_hold  = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        bit         move;
        logic [3:0] pool;
        if (rst) begin
            m_owner = -1;
            m_s     = 0;
            m_last  = 3;
            m_hold  = 0;
        end else begin
            move = 0;
            pool = req;
            if (m_owner < 0 || !req[m_owner]) begin
                move = 1;
`ifdef RR_ARB_HOLD_LIMIT_EN
            end else if (m_hold + 1 >= MH && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
                move = 1;
                pool[m_owner] = 1'b0;
            end else begin
                m_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
`endif
            end
            if (move) begin
                m_owner = -1;
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_last + k) % 4;
                    if (pool[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                if (m_owner >= 0) begin
                    m_s    = m_owner;
                    m_last = m_owner;
                    m_hold = 0;
                end
            end
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("model_S",     32'(bus.S),     32'(m_s));
            chk("model_busy",  32'(bus.busy),  (m_owner < 0) ? 32'd0 : 32'd1);
            chk("model_Y",     32'(bus.Y),     (m_owner < 0) ? 32'd0 : 32'(d[m_s]));
        end
    end

    // Drive req for one edge, then settle just past the following falling edge.
    task automatic apply(input logic [3:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] g, input logic [1:0] s,
                       input logic b, input logic [7:0] y);
        chk({nm, "_grant"}, 32'(bus.grant), 32'(g));
        chk({nm, "_S"},     32'(bus.S),     32'(s));
        chk({nm, "_busy"},  32'(bus.busy),  32'(b));
        chk({nm, "_Y"},     32'(bus.Y),     32'(y));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h5A; d[3] = 8'hC3;
        apply(4'b0000);
        apply(4'b0000);
        lit("reset", 4'b0000, 2'd0, 1'b0, 8'h00);

        rst = 1'b0;
        apply(4'b0001);
        lit("first", 4'b0001, 2'd0, 1'b1, 8'hA5);
        d[0] = 8'h11;
        #1;
        chk("y_follows_d", 32'(bus.Y), 32'h11);
        d[0] = 8'hA5;
        apply(4'b0000);
        lit("drop0", 4'b0000, 2'd0, 1'b0, 8'h00);

        rst = 1'b1;
        apply(4'b1111);
        rst = 1'b0;
        apply(4'b1111);
        lit("all_r0", 4'b0001, 2'd0, 1'b1, 8'hA5);
        apply(4'b1110);
        lit("all_r1", 4'b0010, 2'd1, 1'b1, 8'h3C);
        apply(4'b1100);
        lit("all_r2", 4'b0100, 2'd2, 1'b1, 8'h5A);
        apply(4'b1000);
        lit("all_r3", 4'b1000, 2'd3, 1'b1, 8'hC3);
        apply(4'b0001);
        lit("wrap0", 4'b0001, 2'd0, 1'b1, 8'hA5);

        apply(4'b0100);
        lit("own2", 4'b0100, 2'd2, 1'b1, 8'h5A);
        apply(4'b0000);
        lit("idle_keepS", 4'b0000, 2'd2, 1'b0, 8'h00);
        apply(4'b0100);
        lit("own2b", 4'b0100, 2'd2, 1'b1, 8'h5A);
        rst = 1'b1;
        apply(4'b0100);
        lit("rst_mid", 4'b0000, 2'd0, 1'b0, 8'h00);
        rst = 1'b0;
        apply(4'b0100);
        lit("after_rst", 4'b0100, 2'd2, 1'b1, 8'h5A);

        apply(4'b1011);
        lit("simul_from2", 4'b1000, 2'd3, 1'b1, 8'hC3);

        // 0011 held: owner 3 drops, 0 wins, then hold behaviour decides.
        apply(4'b0011);
        lit("hold_e0", 4'b0001, 2'd0, 1'b1, 8'hA5);
        for (int i = 0; i < 5; i++) apply(4'b0011);
`ifdef RR_ARB_HOLD_LIMIT_EN
        lit("hold_e5", 4'b0010, 2'd1, 1'b1, 8'h3C);
`else
        lit("hold_e5", 4'b0001, 2'd0, 1'b1, 8'hA5);
`endif
        for (int i = 0; i < 6; i++) apply(4'b0011);
        lit("hold_e11", 4'b0001, 2'd0, 1'b1, 8'hA5);

        for (int i = 0; i < 10; i++) apply(4'b0001);
        lit("solo_held", 4'b0001, 2'd0, 1'b1, 8'hA5);

        for (int i = 0; i < 40; i++) begin
            d[i % 4] = 8'($urandom_range(0, 255));
            apply(4'($urandom_range(0, 15)));
        end

        apply(4'b0000);
        lit("final_idle", 4'b0000, bus.S, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
